// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the demux_sched slice.
// Contents: scheduler state encoding and default lane geometry.
package demux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int DEF_NUM_OUT = 8;
    localparam int DEF_SEL_W   = 3;

endpackage

// File: rtl/demux_sched_if.sv
// demux_sched_if: producer-side handshake plus lane-side demux bus.
//   in_valid / in_data / in_ready : single-lane producer handshake
//   lane_ready                    : per-lane ready from consumers
//   sel / lane_data / lane_valid  : demux select, lane payloads, one-hot valid
// modport slave  : the scheduler view
// modport master : the surrounding environment (producer + consumers)
interface demux_sched_if #(
    parameter int NUM_OUT = demux_pkg::DEF_NUM_OUT,
    parameter int SEL_W   = demux_pkg::DEF_SEL_W,
    parameter int DATA_W  = 1
);
    logic                      in_valid;
    logic [DATA_W-1:0]         in_data;
    logic                      in_ready;
    logic [NUM_OUT-1:0]        lane_ready;
    logic [SEL_W-1:0]          sel;
    logic [NUM_OUT*DATA_W-1:0] lane_data;
    logic [NUM_OUT-1:0]        lane_valid;

    modport slave (
        input  in_valid, in_data, lane_ready,
        output in_ready, sel, lane_data, lane_valid
    );

    modport master (
        output in_valid, in_data, lane_ready,
        input  in_ready, sel, lane_data, lane_valid
    );
endinterface

// File: rtl/demux_core.sv
// demux_core: combinational 1-to-NUM_OUT demultiplexer.
//   in  : DATA_W word
//   sel : lane index
//   out : NUM_OUT*DATA_W, lane sel carries in, every other lane is 0
module demux_core #(
    parameter int NUM_OUT = 8,
    parameter int SEL_W   = 3,
    parameter int DATA_W  = 1
) (
    input  logic [DATA_W-1:0]         in,
    input  logic [SEL_W-1:0]          sel,
    output logic [NUM_OUT*DATA_W-1:0] out
);
    always_comb begin
        out = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (sel == SEL_W'(i)) out[i*DATA_W +: DATA_W] = in;
        end
    end
endmodule

// File: rtl/demux_sched.sv
// demux_sched: round-robin dispatcher of one input stream onto NUM_OUT lanes.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : demux_sched_if.slave (producer handshake + lane bus)
//   busy      : high while a word is held on a lane
//   xfer_cnt  : completed transfers, wraps at 2^CNT_W
//   lane_mask : grantable lanes (only with DEMUX_SCHED_MASK_EN defined)
// Optional feature macro: DEMUX_SCHED_MASK_EN
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | waiting for a word from the producer
// ST_SEND | holding a word on lane sel until it is taken
module demux_sched
    import demux_pkg::*;
#(
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int DATA_W  = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    demux_sched_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
`ifdef DEMUX_SCHED_MASK_EN
    ,
    input  logic [NUM_OUT-1:0] lane_mask
`endif
);
    state_t              state, state_nxt;
    logic [NUM_OUT-1:0]  elig;
    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    grant;
    logic [DATA_W-1:0]   hold_data;
    logic [DATA_W-1:0]   demux_in;
    logic                accept;
    logic                complete;

`ifdef DEMUX_SCHED_MASK_EN
    assign elig = bus.lane_ready & lane_mask;
`else
    assign elig = bus.lane_ready;
`endif

    // Scan from the farthest offset back toward rr_ptr so the nearest
    // eligible lane (smallest offset) is the last to win. SEL_W-bit
    // addition wraps modulo NUM_OUT because NUM_OUT is a power of two.
    always_comb begin
        grant = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (elig[rr_ptr + SEL_W'(i)]) grant = rr_ptr + SEL_W'(i);
        end
    end

    assign bus.in_ready = (state == ST_IDLE) && (|elig) && !rst;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    accept    = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // mask is deliberately not re-checked once a lane is granted
                if (bus.lane_ready[sel_q]) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            hold_data <= '0;
            rr_ptr    <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (accept) begin
                sel_q     <= grant;
                hold_data <= bus.in_data;
            end
            if (complete) begin
                rr_ptr   <= sel_q + SEL_W'(1);
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

    assign busy           = (state == ST_SEND);
    assign bus.sel        = sel_q;
    assign bus.lane_valid = busy ? (NUM_OUT'(1) << sel_q) : '0;
    // lanes stay quiet outside SEND even though sel/hold_data keep their values
    assign demux_in       = busy ? hold_data : '0;

    demux_core #(
        .NUM_OUT (NUM_OUT),
        .SEL_W   (SEL_W),
        .DATA_W  (DATA_W)
    ) u_demux_core (
        .in  (demux_in),
        .sel (sel_q),
        .out (bus.lane_data)
    );
endmodule

// File: tb/tb_demux_sched.sv
// tb_demux_sched: directed scenarios followed by random traffic, every
// cycle compared against a transaction-level reference model.
module tb_demux_sched;
    import demux_pkg::*;

    localparam int N  = 8;
    localparam int SW = 3;
    localparam int DW = 1;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [CW-1:0] xfer_cnt;
    logic [N-1:0]  m_mask = '1;

    int checks   = 0;
    int failures = 0;

    // reference model: a word is either in flight on a lane or not
    bit            m_busy = 0;
    int            m_sel  = 0;
    int            m_rr   = 0;
    int            m_hold = 0;
    int            m_cnt  = 0;

    demux_sched_if #(.NUM_OUT(N), .SEL_W(SW), .DATA_W(DW)) bus ();

    demux_sched #(.NUM_OUT(N), .SEL_W(SW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
`ifdef DEMUX_SCHED_MASK_EN
        ,
        .lane_mask(m_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_grant(input int ptr, input logic [N-1:0] e);
        for (int k = 0; k < N; k++)
            if (e[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // One clock: drive inputs, compare outputs with the model, then advance
    // the model across the rising edge.
    task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic [N-1:0] lr);
        logic [N-1:0] e;
        bit           exp_ready;
        int           g;
        @(negedge clk);
        rst            = r;
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.lane_ready = lr;
        #1;
        e         = lr & m_mask;
        g         = rr_grant(m_rr, e);
        exp_ready = !r && !m_busy && (g >= 0);
        chk("in_ready",   32'(bus.in_ready),   32'(exp_ready));
        chk("busy",       32'(busy),           32'(m_busy));
        chk("sel",        32'(bus.sel),        32'(m_sel));
        chk("lane_valid", 32'(bus.lane_valid), m_busy ? (32'd1 << m_sel) : 32'd0);
        chk("lane_data",  32'(bus.lane_data),  m_busy ? (32'(m_hold) << (m_sel * DW)) : 32'd0);
        chk("xfer_cnt",   32'(xfer_cnt),       32'(m_cnt));
        @(posedge clk);
        if (r) begin
            m_busy = 0; m_sel = 0; m_rr = 0; m_hold = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (v && exp_ready) begin
                m_busy = 1; m_sel = g; m_hold = int'(d);
            end
        end else if (lr[m_sel]) begin
            m_busy = 0;
            m_rr   = (m_sel + 1) % N;
            m_cnt  = (m_cnt + 1) % (1 << CW);
        end
    endtask

    initial begin
        int saved_cnt;
        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.lane_ready = '0;

        step(1, 0, 0, '0);
        step(1, 1, 1, '1);
        #2;
        chk("rst_sel",  32'(bus.sel),        32'd0);
        chk("rst_lv",   32'(bus.lane_valid), 32'd0);
        chk("rst_cnt",  32'(xfer_cnt),       32'd0);
        chk("rst_busy", 32'(busy),           32'd0);

        // three back-to-back words, all lanes ready
        for (int w = 0; w < 3; w++) begin
            step(0, 1, 1, '1);
            #2;
            chk("b2b_sel", 32'(bus.sel),        32'(w));
            chk("b2b_lv",  32'(bus.lane_valid), 32'd1 << w);
            step(0, 0, 0, '1);
            #2;
            chk("b2b_pulse", 32'(bus.lane_valid), 32'd0);
        end
        chk("b2b_cnt", 32'(xfer_cnt), 32'd3);
        step(0, 1, 1, '1);
        #2;
        chk("rr_after_b2b", 32'(bus.sel), 32'd3);
        step(0, 0, 0, '1);

        // skip: only lane 2 ready from rr_ptr=0
        step(1, 0, 0, '0);
        step(0, 1, 1, 8'b0000_0100);
        #2;
        chk("skip_sel", 32'(bus.sel),       32'd2);
        chk("skip_ld",  32'(bus.lane_data), 32'h04);
        step(0, 0, 0, 8'b0000_0100);
        step(0, 1, 1, '1);
        #2;
        chk("skip_rr", 32'(bus.sel), 32'd3);
        step(0, 0, 0, '1);

        // wrap: bring rr_ptr to 7 through lane 6
        step(0, 1, 1, 8'b0100_0000);
        step(0, 0, 0, 8'b0100_0000);
        step(0, 1, 1, 8'b0000_0011);
        #2;
        chk("wrap_sel", 32'(bus.sel), 32'd0);
        step(0, 0, 0, 8'b0000_0011);
        step(0, 1, 1, '1);
        #2;
        chk("wrap_rr", 32'(bus.sel), 32'd1);
        step(0, 0, 0, '1);

        // backpressure: lane drops ready for 5 cycles, producer keeps pushing
        step(0, 1, 1, '1);
        saved_cnt = m_cnt;
        for (int i = 0; i < 5; i++) step(0, 1, 0, '0);
        step(0, 0, 0, '1);
        #2;
        chk("bp_cnt",  32'(xfer_cnt), 32'(saved_cnt + 1));
        chk("bp_busy", 32'(busy),     32'd0);

        // reset while a word is in flight
        step(0, 1, 1, 8'b0010_0000);
        step(1, 0, 0, '1);
        #2;
        chk("rst_send_lv",   32'(bus.lane_valid), 32'd0);
        chk("rst_send_sel",  32'(bus.sel),        32'd0);
        chk("rst_send_cnt",  32'(xfer_cnt),       32'd0);
        chk("rst_send_busy", 32'(busy),           32'd0);
        step(0, 1, 1, '1);
        #2;
        chk("rst_send_next", 32'(bus.sel), 32'd0);
        step(0, 0, 0, '1);

`ifdef DEMUX_SCHED_MASK_EN
        step(1, 0, 0, '0);
        m_mask = 8'b1111_1110;
        step(0, 1, 1, '1);
        #2;
        chk("mask_sel", 32'(bus.sel), 32'd1);
        step(0, 0, 0, '1);
        m_mask = '0;
        for (int i = 0; i < 10; i++) step(0, 1, 1, '1);
        m_mask = '1;
`endif

        // random traffic with sparse lane_ready and occasional reset
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] lr;
            for (int b = 0; b < N; b++) lr[b] = ($urandom_range(0, 9) < 3);
`ifdef DEMUX_SCHED_MASK_EN
            if ($urandom_range(0, 15) == 0) m_mask = N'($urandom);
`endif
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 DW'($urandom), lr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
